// File: rtl/reg_array_arbiter_if.sv
// Bundle between the two pipeline clients, the arbiter and the shared regArray.
// The slave modport is the arbiter's view; master is everything around it.
interface reg_array_arbiter_if #(
  parameter int m = 4,
  parameter int n = 4
);
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [m-1:0] addr0;
  logic [m-1:0] addr1;
  logic [n-1:0] wdata0;
  logic [n-1:0] wdata1;
  logic         ack0;
  logic         ack1;
  logic [n-1:0] rdata0;
  logic [n-1:0] rdata1;
  logic         busy;
  logic         ra_writeEnable;
  logic [m-1:0] ra_writeAddr;
  logic [m-1:0] ra_readAddr;
  logic [n-1:0] ra_dataIn;
  logic [n-1:0] ra_dataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ra_dataOut,
    output ack0, ack1, rdata0, rdata1, busy,
           ra_writeEnable, ra_writeAddr, ra_readAddr, ra_dataIn
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ra_dataOut,
    input  ack0, ack1, rdata0, rdata1, busy,
           ra_writeEnable, ra_writeAddr, ra_readAddr, ra_dataIn
  );
endinterface

// File: rtl/reg_array_arbiter.sv
// Round-robin arbiter sharing one regArray between two req/ack requesters.
// Each op walks IDLE -> ISSUE -> DONE; all outputs are registered.
module reg_array_arbiter #(
  parameter int m = 4,
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                clr,
  reg_array_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q;
  logic         owner_q;
  logic         we_q;
  logic         ptr_q;
  logic         ack0_q;
  logic         ack1_q;
  logic         busy_q;
  logic [n-1:0] rdata0_q;
  logic [n-1:0] rdata1_q;
  logic         raWe_q;
  logic [m-1:0] raWAddr_q;
  logic [m-1:0] raRAddr_q;
  logic [n-1:0] raDataIn_q;

  logic         grantOwner_d;
  logic         grantWe_d;
  logic [m-1:0] grantAddr_d;
  logic [n-1:0] grantData_d;

  // ptr only matters when both requesters compete; a lone request always wins.
  always_comb begin
    grantOwner_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      grantOwner_d = ptr_q;
    end else if (bus.req1) begin
      grantOwner_d = 1'b1;
    end
    grantWe_d   = grantOwner_d ? bus.we1    : bus.we0;
    grantAddr_d = grantOwner_d ? bus.addr1  : bus.addr0;
    grantData_d = grantOwner_d ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      ptr_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      raWe_q     <= 1'b0;
      raWAddr_q  <= '0;
      raRAddr_q  <= '0;
      raDataIn_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_q    <= grantOwner_d;
            we_q       <= grantWe_d;
            raWe_q     <= grantWe_d;
            raWAddr_q  <= grantAddr_d;
            raRAddr_q  <= grantAddr_d;
            raDataIn_q <= grantData_d;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        // The array has written on the falling edge; a read is sampled here.
        ISSUE: begin
          raWe_q <= 1'b0;
          if (!we_q) begin
            if (owner_q) rdata1_q <= bus.ra_dataOut;
            else         rdata0_q <= bus.ra_dataOut;
          end
          ack0_q  <= ~owner_q;
          ack1_q  <= owner_q;
          ptr_q   <= ~owner_q;
          state_q <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.busy           = busy_q;
  assign bus.ra_writeEnable = raWe_q;
  assign bus.ra_writeAddr   = raWAddr_q;
  assign bus.ra_readAddr    = raRAddr_q;
  assign bus.ra_dataIn      = raDataIn_q;

endmodule

// File: tb/tb_reg_array_arbiter.sv
// Directed bench for reg_array_arbiter with a small regArray model hung on the bus.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_reg_array_arbiter;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  reg_array_arbiter_if #(.m(4), .n(4)) bus ();

  reg_array_arbiter #(.m(4), .n(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // regArray stand-in: writes on the falling edge, combinational read, cleared by clr.
  logic [3:0] mem [16];
  always @(negedge clk) begin
    if (!clr) begin
      for (int j = 0; j < 16; j++) mem[j] <= 4'h0;
    end else if (bus.ra_writeEnable) begin
      mem[bus.ra_writeAddr] <= bus.ra_dataIn;
    end
  end
  assign bus.ra_dataOut = mem[bus.ra_readAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    clr = 1'b0;
    repeat (2) waitCycle();
    clr = 1'b1;
  endtask

  // One complete op by a single requester starting in IDLE; expRdata is the
  // value that requester's rdata must show at its ack (unchanged on writes).
  task automatic applyStimulus(input int who, input logic weV, input logic [3:0] addrV,
                               input logic [3:0] wdataV, input logic [3:0] expRdata,
                               input string tag);
    if (who == 0) begin
      bus.req0 = 1'b1; bus.we0 = weV; bus.addr0 = addrV; bus.wdata0 = wdataV;
    end else begin
      bus.req1 = 1'b1; bus.we1 = weV; bus.addr1 = addrV; bus.wdata1 = wdataV;
    end
    waitCycle();
    checkOutput({tag, "_issueAck"}, (who == 0) ? bus.ack0 : bus.ack1, 1'b0);
    checkOutput({tag, "_issueBusy"}, bus.busy, 1'b1);
    checkOutput({tag, "_issueWe"}, bus.ra_writeEnable, weV);
    checkOutput({tag, "_issueWAddr"}, bus.ra_writeAddr, addrV);
    checkOutput({tag, "_issueRAddr"}, bus.ra_readAddr, addrV);
    if (weV) checkOutput({tag, "_issueDataIn"}, bus.ra_dataIn, wdataV);
    waitCycle();
    checkOutput({tag, "_ackOwn"}, (who == 0) ? bus.ack0 : bus.ack1, 1'b1);
    checkOutput({tag, "_ackOther"}, (who == 0) ? bus.ack1 : bus.ack0, 1'b0);
    checkOutput({tag, "_ackWe"}, bus.ra_writeEnable, 1'b0);
    checkOutput({tag, "_rdata"}, (who == 0) ? bus.rdata0 : bus.rdata1, expRdata);
    if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    waitCycle();
    checkOutput({tag, "_idleAck"}, (who == 0) ? bus.ack0 : bus.ack1, 1'b0);
    checkOutput({tag, "_idleBusy"}, bus.busy, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = 4'h0; bus.addr1 = 4'h0;
    bus.wdata0 = 4'h0; bus.wdata1 = 4'h0;

    $display("[TB] T1 reset");
    doReset();
    checkOutput("T1_ack0", bus.ack0, 1'b0);
    checkOutput("T1_ack1", bus.ack1, 1'b0);
    checkOutput("T1_busy", bus.busy, 1'b0);
    checkOutput("T1_we", bus.ra_writeEnable, 1'b0);
    checkOutput("T1_rdata0", bus.rdata0, 4'h0);
    checkOutput("T1_rdata1", bus.rdata1, 4'h0);
    checkOutput("T1_wAddr", bus.ra_writeAddr, 4'h0);
    checkOutput("T1_dataIn", bus.ra_dataIn, 4'h0);

    $display("[TB] T2 single op");
    applyStimulus(0, 1'b1, 4'd3, 4'hA, 4'h0, "T2_wr3");
    applyStimulus(0, 1'b0, 4'd3, 4'h0, 4'hA, "T2_rd3");
    checkOutput("T2_rdata1", bus.rdata1, 4'h0);

    $display("[TB] T3 contention");
    doReset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    for (int i = 1; i <= 12; i++) begin
      waitCycle();
      checkOutput($sformatf("T3_ack0_c%0d", i), bus.ack0, (i == 2 || i == 8) ? 1'b1 : 1'b0);
      checkOutput($sformatf("T3_ack1_c%0d", i), bus.ack1, (i == 5 || i == 11) ? 1'b1 : 1'b0);
      checkOutput($sformatf("T3_we_c%0d", i), bus.ra_writeEnable, 1'b0);
      if (i == 11) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end

    $display("[TB] T4 ordering");
    doReset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd5; bus.wdata1 = 4'h3;
    for (int i = 1; i <= 6; i++) begin
      waitCycle();
      checkOutput($sformatf("T4_we_c%0d", i), bus.ra_writeEnable, (i == 4) ? 1'b1 : 1'b0);
      if (i == 2) begin
        checkOutput("T4_ack0", bus.ack0, 1'b1);
        checkOutput("T4_oldData", bus.rdata0, 4'h0);
        bus.req0 = 1'b0;
      end
      if (i == 5) begin
        checkOutput("T4_ack1", bus.ack1, 1'b1);
        bus.req1 = 1'b0;
      end
    end
    applyStimulus(0, 1'b0, 4'd5, 4'h0, 4'h3, "T4_reread");

    $display("[TB] T5 reset mid-op");
    doReset();
    applyStimulus(0, 1'b1, 4'd2, 4'h4, 4'h0, "T5_pre");
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    waitCycle();
    checkOutput("T5_inIssue", bus.busy, 1'b1);
    clr = 1'b0;
    waitCycle();
    checkOutput("T5_ack1", bus.ack1, 1'b0);
    checkOutput("T5_busy", bus.busy, 1'b0);
    checkOutput("T5_rdata1", bus.rdata1, 4'h0);
    checkOutput("T5_we", bus.ra_writeEnable, 1'b0);
    bus.req1 = 1'b0;
    waitCycle();
    checkOutput("T5_ack1Hold", bus.ack1, 1'b0);
    clr = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd2;
    bus.req1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      waitCycle();
      checkOutput($sformatf("T5_ptrAck0_c%0d", i), bus.ack0, (i == 2) ? 1'b1 : 1'b0);
      checkOutput($sformatf("T5_ptrAck1_c%0d", i), bus.ack1, (i == 5) ? 1'b1 : 1'b0);
      if (i == 2) bus.req0 = 1'b0;
      if (i == 5) bus.req1 = 1'b0;
    end
    waitCycle();

    $display("[TB] T6 boundary addresses");
    applyStimulus(1, 1'b1, 4'd15, 4'hF, 4'h0, "T6_wr15");
    applyStimulus(1, 1'b1, 4'd0,  4'h1, 4'h0, "T6_wr0");
    applyStimulus(1, 1'b0, 4'd15, 4'h0, 4'hF, "T6_rd15");
    applyStimulus(1, 1'b0, 4'd0,  4'h0, 4'h1, "T6_rd0");
    checkOutput("T6_rdata0", bus.rdata0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
